// File: rtl/sdram_mem_tester.sv
// sdram_mem_tester: LFSR write/read-back traffic generator for the SDRAM controller system bus.
// Fills [start_addr, end_addr] with a pattern, reads it back in order and reports pass/fail plus the first error.
module sdram_mem_tester #(
  parameter int AW       = 23,
  parameter int DW       = 16,
  parameter int MAX_OUTS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic [15:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          range_err,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [15:0]   first_err_exp,
  output logic [15:0]   first_err_got,
  output logic          bus_req_read,
  output logic          bus_req_write,
  output logic [AW-1:0] bus_req_addr,
  output logic [DW-1:0] bus_req_wdata,
  output logic [1:0]    bus_req_byteenable,
  input  logic          bus_req_ready,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [3:0]  OUTS_LIMIT = 4'(MAX_OUTS);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] start_q;
  logic [AW-1:0] end_q;
  logic [AW-1:0] chk_addr;
  logic [15:0]   seed_q;
  logic [15:0]   issue_lfsr;
  logic [15:0]   chk_lfsr;
  logic [3:0]    outs;
  logic [15:0]   seed_eff;
  logic          rd_acc;
  logic          wr_acc;
  logic          rsp_acc;
  logic          rsp_mismatch;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

  assign busy               = (state != IDLE);
  assign bus_req_write      = (state == WRITE);
  assign bus_req_read       = (state == READ) && (outs < OUTS_LIMIT);
  assign bus_req_addr       = addr;
  assign bus_req_wdata      = issue_lfsr;
  assign bus_req_byteenable = 2'b11;

  assign rd_acc       = bus_req_read && bus_req_ready;
  assign wr_acc       = bus_req_write && bus_req_ready;
  assign rsp_acc      = bus_rsp_valid && (outs != 4'd0) && ((state == READ) || (state == DRAIN));
  assign rsp_mismatch = rsp_acc && (bus_rsp_rdata != chk_lfsr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      start_q        <= '0;
      end_q          <= '0;
      chk_addr       <= '0;
      seed_q         <= 16'h0001;
      issue_lfsr     <= '0;
      chk_lfsr       <= '0;
      outs           <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      range_err      <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (start_addr <= end_addr) begin
              state          <= WRITE;
              addr           <= start_addr;
              start_q        <= start_addr;
              end_q          <= end_addr;
              chk_addr       <= start_addr;
              seed_q         <= seed_eff;
              issue_lfsr     <= seed_eff;
              chk_lfsr       <= seed_eff;
              done           <= 1'b0;
              pass           <= 1'b0;
              range_err      <= 1'b0;
              err_count      <= '0;
              first_err_addr <= '0;
              first_err_exp  <= '0;
              first_err_got  <= '0;
            end else begin
              done      <= 1'b1;
              range_err <= 1'b1;
              pass      <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (wr_acc) begin
            if (addr == end_q) begin
              state      <= READ;
              addr       <= start_q;
              issue_lfsr <= seed_q;
              chk_lfsr   <= seed_q;
              chk_addr   <= start_q;
            end else begin
              addr       <= addr + ADDR_ONE;
              issue_lfsr <= lfsr_step(issue_lfsr);
            end
          end
        end
        READ: begin
          if (rd_acc) begin
            if (addr == end_q) begin
              state <= DRAIN;
            end else begin
              addr       <= addr + ADDR_ONE;
              issue_lfsr <= lfsr_step(issue_lfsr);
            end
          end
        end
        DRAIN: begin
          if (outs == 4'd0) begin
            state <= IDLE;
            done  <= 1'b1;
            pass  <= (err_count == 16'h0000);
          end
        end
        default: state <= IDLE;
      endcase

      // Responses return in request order, so the check LFSR just walks alongside them.
      if (rsp_acc) begin
        chk_lfsr <= lfsr_step(chk_lfsr);
        chk_addr <= chk_addr + ADDR_ONE;
        if (rsp_mismatch) begin
          if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
          end
          if (err_count == 16'h0000) begin
            first_err_addr <= chk_addr;
            first_err_exp  <= chk_lfsr;
            first_err_got  <= bus_rsp_rdata;
          end
        end
      end

      outs <= outs + {3'b000, rd_acc} - {3'b000, rsp_acc};
    end
  end

endmodule

// File: tb/tb_sdram_mem_tester.sv
// tb_sdram_mem_tester: scoreboard bench with a latency-configurable memory model behind the tester.
// Expected writes, read addresses and final results are queued at stimulus time and popped by a monitor.
module tb_sdram_mem_tester;

  localparam int AW       = 23;
  localparam int DW       = 16;
  localparam int MAX_OUTS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [15:0]   seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic          range_err;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [15:0]   first_err_exp;
  logic [15:0]   first_err_got;
  logic          bus_req_read;
  logic          bus_req_write;
  logic [AW-1:0] bus_req_addr;
  logic [DW-1:0] bus_req_wdata;
  logic [1:0]    bus_req_byteenable;
  logic          bus_req_ready;
  logic          bus_rsp_valid;
  logic [DW-1:0] bus_rsp_rdata;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic          pass;
    logic          range_err;
    logic [15:0]   err_count;
    logic [AW-1:0] fa;
    logic [15:0]   fe;
    logic [15:0]   fg;
  } res_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  res_t          exp_res[$];
  rsp_t          pipe[$];
  logic [15:0]   mem [0:255];

  int   vectors      = 0;
  int   miscompares  = 0;
  int   cyc          = 0;
  int   lat          = 3;
  int   stall_cycles = 0;
  int   inflight     = 0;
  bit   flip_en      = 1'b0;
  rsp_t new_rsp;
  res_t res;

  sdram_mem_tester #(.AW(AW), .DW(DW), .MAX_OUTS(MAX_OUTS)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .start_addr         (start_addr),
    .end_addr           (end_addr),
    .seed               (seed),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .range_err          (range_err),
    .err_count          (err_count),
    .first_err_addr     (first_err_addr),
    .first_err_exp      (first_err_exp),
    .first_err_got      (first_err_got),
    .bus_req_read       (bus_req_read),
    .bus_req_write      (bus_req_write),
    .bus_req_addr       (bus_req_addr),
    .bus_req_wdata      (bus_req_wdata),
    .bus_req_byteenable (bus_req_byteenable),
    .bus_req_ready      (bus_req_ready),
    .bus_rsp_valid      (bus_rsp_valid),
    .bus_rsp_rdata      (bus_rsp_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: event occurred with nothing expected", name);
  endtask

  // Memory model: ready/stall control, ordered read responses after 'lat' cycles, optional bit-0 flip at address 5.
  initial begin
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_cycles > 0) begin
        bus_req_ready = 1'b0;
        stall_cycles--;
      end else begin
        bus_req_ready = 1'b1;
      end
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = pipe[0].data;
        void'(pipe.pop_front());
        inflight--;
      end else begin
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0;
      end
      if (!rst && bus_req_ready) begin
        if (bus_req_write) begin
          mem[bus_req_addr[7:0]] = bus_req_wdata;
        end
        if (bus_req_read) begin
          new_rsp.due  = cyc + lat;
          new_rsp.data = mem[bus_req_addr[7:0]] ^ ((flip_en && bus_req_addr == 5) ? 16'h0001 : 16'h0000);
          pipe.push_back(new_rsp);
          inflight++;
          checkOutput("reads_in_flight_le_max", 32'(inflight <= MAX_OUTS), 32'd1);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an accepted request or a new result.
  initial begin
    logic done_q;
    wr_t  w;
    res_t r;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus_req_ready && bus_req_write) begin
        if (exp_wr.size() == 0) begin
          flagFail("unexpected_write");
        end else begin
          w = exp_wr.pop_front();
          checkOutput("write_addr", 32'(bus_req_addr), 32'(w.addr));
          checkOutput("write_data", 32'(bus_req_wdata), 32'(w.data));
        end
      end
      if (!rst && bus_req_ready && bus_req_read) begin
        if (exp_rd.size() == 0) begin
          flagFail("unexpected_read");
        end else begin
          checkOutput("read_addr", 32'(bus_req_addr), 32'(exp_rd.pop_front()));
        end
      end
      if (done && !done_q) begin
        if (exp_res.size() == 0) begin
          flagFail("unexpected_done");
        end else begin
          r = exp_res.pop_front();
          checkOutput("result_pass", 32'(pass), 32'(r.pass));
          checkOutput("result_range_err", 32'(range_err), 32'(r.range_err));
          checkOutput("result_err_count", 32'(err_count), 32'(r.err_count));
          checkOutput("result_first_err_addr", 32'(first_err_addr), 32'(r.fa));
          checkOutput("result_first_err_exp", 32'(first_err_exp), 32'(r.fe));
          checkOutput("result_first_err_got", 32'(first_err_got), 32'(r.fg));
        end
      end
      done_q = done;
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic [15:0] sd,
                               input int latency, input bit flip, input res_t expect_res, input bit push_res);
    logic [15:0] s;
    lat     = latency;
    flip_en = flip;
    if (sa <= ea) begin
      s = (sd == 16'h0000) ? 16'h0001 : sd;
      for (int a = int'(sa); a <= int'(ea); a++) begin
        exp_wr.push_back('{addr: AW'(a), data: s});
        exp_rd.push_back(AW'(a));
        s = model_step(s);
      end
    end
    if (push_res) exp_res.push_back(expect_res);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = sa;
    end_addr   = ea;
    seed       = sd;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (sa <= ea) begin
      checkOutput("write_req_cycle_after_start", 32'(bus_req_write), 32'd1);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
    end else begin
      checkOutput("range_done_next_cycle", 32'(done), 32'd1);
      checkOutput("range_err_next_cycle", 32'(range_err), 32'd1);
      checkOutput("range_pass_next_cycle", 32'(pass), 32'd0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        checkOutput("range_no_bus_req", 32'({bus_req_read, bus_req_write, busy}), 32'd0);
      end
    end
  endtask

  task automatic waitResult(input string name);
    int n;
    n = 0;
    while (exp_res.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_res.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: done not seen, got %0d pending results, expected 0", name, exp_res.size());
      exp_res.delete();
    end
    @(negedge clk);
    checkOutput({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    checkOutput({name, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  initial begin
    logic [AW-1:0] hold_addr;
    logic [15:0]   hold_data;
    int            n;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    seed       = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    checkOutput("reset_range_err", 32'(range_err), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    checkOutput("reset_bus_req", 32'({bus_req_read, bus_req_write}), 32'd0);
    checkOutput("reset_byteenable", 32'(bus_req_byteenable), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] illegal range 8..4");
    res = '{pass: 1'b0, range_err: 1'b1, err_count: 16'h0, fa: '0, fe: 16'h0, fg: 16'h0};
    applyStimulus(AW'(8), AW'(4), 16'h0001, 3, 1'b0, res, 1'b1);
    waitResult("range");

    $display("[TB] range 0..15 seed 1 latency 3");
    res = '{pass: 1'b1, range_err: 1'b0, err_count: 16'h0, fa: '0, fe: 16'h0, fg: 16'h0};
    applyStimulus(AW'(0), AW'(15), 16'h0001, 3, 1'b0, res, 1'b1);
    waitResult("basic");

    // Seed 1 at step 5: 0001 -> B400 -> 5A00 -> 2D00 -> 1680 -> 0B40.
    $display("[TB] range 0..15 with bit 0 flipped at address 5");
    res = '{pass: 1'b0, range_err: 1'b0, err_count: 16'h1, fa: AW'(5), fe: 16'h0B40, fg: 16'h0B41};
    applyStimulus(AW'(0), AW'(15), 16'h0001, 3, 1'b1, res, 1'b1);
    waitResult("flip");

    $display("[TB] range 0..31 seed 0 latency 6");
    res = '{pass: 1'b1, range_err: 1'b0, err_count: 16'h0, fa: '0, fe: 16'h0, fg: 16'h0};
    applyStimulus(AW'(0), AW'(31), 16'h0000, 6, 1'b0, res, 1'b1);
    waitResult("latency6");

    $display("[TB] ready stalled 10 cycles mid-write");
    applyStimulus(AW'(0), AW'(15), 16'hACE1, 3, 1'b0, res, 1'b1);
    n = 0;
    while (exp_wr.size() > 11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    stall_cycles = 10;
    @(negedge clk);
    #2;
    hold_addr = bus_req_addr;
    hold_data = bus_req_wdata;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      #2;
      checkOutput("stall_write_held", 32'(bus_req_write), 32'd1);
      checkOutput("stall_addr_stable", 32'(bus_req_addr), 32'(hold_addr));
      checkOutput("stall_wdata_stable", 32'(bus_req_wdata), 32'(hold_data));
    end
    waitResult("stall");

    $display("[TB] reset during read with requests outstanding");
    applyStimulus(AW'(0), AW'(31), 16'h1234, 6, 1'b0, res, 1'b0);
    n = 0;
    while (exp_rd.size() > 29 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reads_outstanding_before_reset", 32'(inflight > 0), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_bus_req", 32'({bus_req_read, bus_req_write}), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err_count", 32'(err_count), 32'd0);
    exp_wr.delete();
    exp_rd.delete();
    res = '{pass: 1'b1, range_err: 1'b0, err_count: 16'h0, fa: '0, fe: 16'h0, fg: 16'h0};
    applyStimulus(AW'(0), AW'(7), 16'h00FF, 3, 1'b0, res, 1'b1);
    waitResult("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/sdram_mem_tester.md
# sdram_mem_tester

Self-checking traffic generator that drives the SDRAM controller's system bus in place of the JTAG host. It writes an LFSR pattern over an inclusive word-address range, then reads the range back and compares. It counts mismatches and records the first failure. It sits directly upstream of the SDRAM controller and gives board bring-up a pass/fail result without host software.

## Interface
Parameters:
- AW, 23, bus word-address width
- DW, 16, data width (the LFSR is fixed at 16 bits, so DW must be 16)
- MAX_OUTS, 4, maximum reads in flight (1..15)

Ports:
- clk  in  1  system clock, same domain as the SDRAM controller
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle start pulse; ignored while busy=1
- start_addr  in  AW  first word address, sampled on start
- end_addr  in  AW  last word address (inclusive), sampled on start
- seed  in  16  LFSR seed, sampled on start; value 0 is replaced by 16'h0001
- busy  out  1  test running
- done  out  1  level; set at test end, cleared by the next accepted start
- pass  out  1  valid when done=1: no errors and a legal range
- range_err  out  1  start_addr > end_addr at start
- err_count  out  16  mismatch count, saturates at 16'hFFFF
- first_err_addr  out  AW  address of the first mismatch
- first_err_exp  out  16  expected data at the first mismatch
- first_err_got  out  16  read data at the first mismatch
- bus_req_read  out  1  read request
- bus_req_write  out  1  write request
- bus_req_addr  out  AW  request address
- bus_req_wdata  out  DW  write data
- bus_req_byteenable  out  2  constant 2'b11
- bus_req_ready  in  1  controller accepts the request this cycle
- bus_rsp_valid  in  1  read data valid, in request order
- bus_rsp_rdata  in  DW  read data

## Operation
- Pattern is a Galois right-shift LFSR with mask 16'hB400.
  - Step rule: next = (s>>1) ^ (s[0] ? 16'hB400 : 0).
  - Address start_addr+i gets the state after i steps from the seed.
  - Seed 1 gives 0x0001, 0xB400, 0x5A00, ...
- The block keeps two LFSRs, one for issuing and one for checking. Both are loaded with the seed on start and on entry to READ.
- FSM states:
  - IDLE: on start with start_addr ≤ end_addr → WRITE, clear done, err_count and first_err_*. On start with start_addr > end_addr → stay in IDLE, set done=1, range_err=1, pass=0, no bus activity.
  - WRITE: hold bus_req_write=1. On acceptance (write & ready), increment the address and step the issue LFSR. When the accepted address equals end_addr → READ, with address reset to start_addr and LFSRs reloaded.
  - READ: assert bus_req_read while outs < MAX_OUTS. On acceptance, increment the address and outs. When the accepted address equals end_addr → DRAIN.
  - DRAIN: wait for outs==0 → IDLE, set done=1, pass=(err_count==0).
- Response check (READ and DRAIN):
  - Each bus_rsp_valid is compared against the check LFSR, then the check LFSR and check address step.
  - On mismatch, err_count increments (saturating). If err_count was 0, first_err_* are captured.
- outs counter: +1 on read acceptance, −1 on response. Both events in the same cycle leave it unchanged.
- bus_rsp_valid in IDLE or WRITE, or with outs==0, is ignored.
- The address counter is AW bits wide. Termination uses equality with end_addr, so there is no wrap; end_addr = all-ones terminates correctly.
- Outputs on reset: every output 0 except bus_req_byteenable (2'b11). FSM returns to IDLE and outs clears.
- Reset mid-test aborts the test. Requests drop in the cycle after rst is sampled. Later responses are ignored.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from bus_req_ready to bus_req_*.
- A request is accepted in any cycle with req & bus_req_ready.
  - While a request is not accepted, bus_req_addr and bus_req_wdata are held stable.
  - After acceptance, the next request may be presented in the following cycle, giving back-to-back throughput of one per cycle.
- The first write request is asserted one cycle after the start pulse.
- WRITE→READ: the first read request is presented in the cycle after the last write is accepted.
- err_count and first_err_* update one cycle after the bus_rsp_valid that caused them.
- done and pass assert one cycle after the final response is checked.
- busy=1 from the cycle after start until the cycle done rises.

## Test plan
- Range 0..15, seed 1, ideal memory model with 3-cycle read latency, ready=1 → 16 writes with data 0x0001, 0xB400, 0x5A00, ...; 16 reads; done=1, pass=1, err_count=0.
- Same run with the memory model flipping bit 0 at address 5 → err_count=1, first_err_addr=5, first_err_exp=value at step 5, first_err_got=first_err_exp^1, pass=0.
- MAX_OUTS=2, read latency 6, range 0..31 → reads in flight never exceed 2; pass=1.
- bus_req_ready held low for 10 cycles mid-WRITE → addr and wdata stable throughout; no skipped or duplicated address; pass=1.
- start_addr=8, end_addr=4 → next cycle done=1, range_err=1, pass=0; no bus request ever asserted.
- rst pulsed during READ with reads outstanding → all outputs 0 the next cycle; stale responses ignored; a new start over 0..7 passes with err_count=0.
